// File: rtl/mmio_host_controller_pkg.sv
// Shared MMIO definitions: bus widths, timeout counter width
// and the host-side transaction state encoding.
package mmio_host_controller_pkg;

    localparam int TIA_MMIO_INDEX_WIDTH       = 8;
    localparam int TIA_MMIO_DATA_WIDTH        = 32;
    localparam int MMIO_TIMEOUT_COUNTER_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        RESPOND    = 2'd3
    } mmio_host_state_t;

endpackage

// File: rtl/mmio_if.sv
// Core MMIO port: held request/acknowledge for reads and writes.
// The host drives requests, the memory mapper drives acknowledges.
interface mmio_if;
    import mmio_host_controller_pkg::*;

    logic                            read_req;
    logic [TIA_MMIO_INDEX_WIDTH-1:0] read_index;
    logic                            read_ack;
    logic [TIA_MMIO_DATA_WIDTH-1:0]  read_data;
    logic                            write_req;
    logic [TIA_MMIO_INDEX_WIDTH-1:0] write_index;
    logic [TIA_MMIO_DATA_WIDTH-1:0]  write_data;
    logic                            write_ack;

    modport host (
        output read_req, read_index, write_req, write_index, write_data,
        input  read_ack, read_data, write_ack
    );

    modport device (
        input  read_req, read_index, write_req, write_index, write_data,
        output read_ack, read_data, write_ack
    );

endinterface

// File: rtl/mmio_host_controller.sv
// MMIO initiator: one command at a time onto mmio_if.host, with a
// per-transaction timeout that turns a missing ack into an error.
module mmio_host_controller
    import mmio_host_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [TIA_MMIO_INDEX_WIDTH-1:0] cmd_index,
    input  logic [TIA_MMIO_DATA_WIDTH-1:0]  cmd_data,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic [TIA_MMIO_DATA_WIDTH-1:0]  resp_data,
    output logic                            resp_error,
    mmio_if.host                            mmio
);

    localparam int CW = MMIO_TIMEOUT_COUNTER_WIDTH;
    localparam logic [CW-1:0] TIMEOUT_LAST =
        CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    mmio_host_state_t state;
    mmio_host_state_t state_next;
    logic [CW-1:0]    timeout_count;
    logic             expired;

    // Expiry only matters when no ack arrives that cycle; ack wins.
    assign expired    = (TIMEOUT_CYCLES != 0) && (timeout_count == TIMEOUT_LAST);
    assign cmd_ready  = (state == IDLE);
    assign resp_valid = (state == RESPOND);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_valid)
                    state_next = cmd_write ? WRITE_WAIT : READ_WAIT;
            end
            READ_WAIT: begin
                if (mmio.read_ack || expired)
                    state_next = RESPOND;
            end
            WRITE_WAIT: begin
                if (mmio.write_ack || expired)
                    state_next = RESPOND;
            end
            RESPOND: begin
                if (resp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            timeout_count    <= '0;
            resp_data        <= '0;
            resp_error       <= 1'b0;
            mmio.read_req    <= 1'b0;
            mmio.read_index  <= '0;
            mmio.write_req   <= 1'b0;
            mmio.write_index <= '0;
            mmio.write_data  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        timeout_count <= '0;
                        if (cmd_write) begin
                            mmio.write_req   <= 1'b1;
                            mmio.write_index <= cmd_index;
                            mmio.write_data  <= cmd_data;
                        end else begin
                            mmio.read_req    <= 1'b1;
                            mmio.read_index  <= cmd_index;
                        end
                    end
                end
                READ_WAIT: begin
                    if (mmio.read_ack || expired) begin
                        resp_data       <= mmio.read_ack ? mmio.read_data : '0;
                        resp_error      <= !mmio.read_ack;
                        mmio.read_req   <= 1'b0;
                        mmio.read_index <= '0;
                    end else begin
                        timeout_count <= timeout_count + CW'(1);
                    end
                end
                WRITE_WAIT: begin
                    if (mmio.write_ack || expired) begin
                        resp_data        <= '0;
                        resp_error       <= !mmio.write_ack;
                        mmio.write_req   <= 1'b0;
                        mmio.write_index <= '0;
                        mmio.write_data  <= '0;
                    end else begin
                        timeout_count <= timeout_count + CW'(1);
                    end
                end
                RESPOND: begin
                    if (resp_ready) begin
                        resp_data  <= '0;
                        resp_error <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_host_controller.sv
// Bench for mmio_host_controller: scripted device with programmable
// ack latency, plus an array-based reference memory.
module tb_mmio_host_controller;
    import mmio_host_controller_pkg::*;

    localparam int IW = TIA_MMIO_INDEX_WIDTH;
    localparam int DW = TIA_MMIO_DATA_WIDTH;

    logic          clock;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [IW-1:0] cmd_index;
    logic [DW-1:0] cmd_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          resp_error;

    mmio_if mio();

    logic          dev_en;
    int            dev_lat;
    int            dev_cnt;
    logic          dev_rack;
    logic          dev_wack;
    logic          extra_wack;
    logic [DW-1:0] dev_rdata;
    bit   [DW-1:0] dev_mem [256];
    bit   [DW-1:0] ref_mem [256];

    int total;
    int bad;

    assign mio.read_ack  = dev_rack;
    assign mio.read_data = dev_rdata;
    assign mio.write_ack = dev_wack | extra_wack;

    mmio_host_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_index  (cmd_index),
        .cmd_data   (cmd_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_error (resp_error),
        .mmio       (mio)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Device acks in request cycle dev_lat+1 (dev_lat=0: first cycle).
    always @(negedge clock) begin
        dev_rack <= 1'b0;
        dev_wack <= 1'b0;
        if (dev_en && (mio.read_req || mio.write_req)) begin
            if (dev_cnt == dev_lat) begin
                if (mio.read_req) begin
                    dev_rack  <= 1'b1;
                    dev_rdata <= dev_mem[mio.read_index];
                end else begin
                    dev_wack <= 1'b1;
                    dev_mem[mio.write_index] <= mio.write_data;
                end
            end
            dev_cnt <= dev_cnt + 1;
        end else begin
            dev_cnt <= 0;
        end
    end

    // Issue one command at a negedge while idle; return at the negedge
    // where resp_valid is seen (or after the cycle budget runs out).
    task automatic run_cmd(input bit wr, input logic [IW-1:0] idx,
                           input logic [DW-1:0] d, output int reqc,
                           output bit proto_ok, output bit got_resp);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_index = idx;
        cmd_data  = d;
        @(negedge clock);
        cmd_valid = 1'b0;
        reqc      = 0;
        proto_ok  = 1'b1;
        got_resp  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (mio.read_req && mio.write_req) proto_ok = 1'b0;
            if (wr ? mio.read_req : mio.write_req) proto_ok = 1'b0;
            if (cmd_ready) proto_ok = 1'b0;
            if (resp_valid) begin
                got_resp = 1'b1;
                break;
            end
            if (wr ? mio.write_req : mio.read_req) begin
                reqc++;
                if (wr && (mio.write_index !== idx || mio.write_data !== d))
                    proto_ok = 1'b0;
                if (!wr && mio.read_index !== idx)
                    proto_ok = 1'b0;
            end else begin
                proto_ok = 1'b0;
            end
            @(negedge clock);
        end
        if (got_resp && (mio.read_req || mio.write_req ||
                         mio.read_index != 0 || mio.write_index != 0 ||
                         mio.write_data != 0))
            proto_ok = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({cmd_ready, resp_valid, resp_error} !== 3'b100 || resp_data !== '0) begin
            bad++;
            $display("FAIL reset_resp: ready/valid/err=%b data=%h want 100/0",
                     {cmd_ready, resp_valid, resp_error}, resp_data);
        end
        total++;
        if ({mio.read_req, mio.write_req} !== 2'b00 || mio.read_index !== '0 ||
            mio.write_index !== '0 || mio.write_data !== '0) begin
            bad++;
            $display("FAIL reset_mmio: req=%b ri=%h wi=%h wd=%h want all 0",
                     {mio.read_req, mio.write_req}, mio.read_index,
                     mio.write_index, mio.write_data);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_write();
        int reqc;
        bit ok, got;
        dev_en  = 1'b1;
        dev_lat = 0;
        run_cmd(1'b1, 8'h42, 32'h1234_5678, reqc, ok, got);
        ref_mem[8'h42] = 32'h1234_5678;
        total++;
        if (!got || reqc !== 1 || !ok) begin
            bad++;
            $display("FAIL write_handshake: got=%0b reqcycles=%0d ok=%0b want 1/1/1",
                     got, reqc, ok);
        end
        total++;
        if (resp_data !== '0 || resp_error !== 1'b0) begin
            bad++;
            $display("FAIL write_resp: data=%h err=%b want 0/0", resp_data, resp_error);
        end
        @(negedge clock);
        total++;
        if (cmd_ready !== 1'b1 || dev_mem[8'h42] !== 32'h1234_5678) begin
            bad++;
            $display("FAIL write_done: ready=%b mem=%h want 1/12345678",
                     cmd_ready, dev_mem[8'h42]);
        end
    endtask

    task automatic test_read();
        int reqc;
        bit ok, got;
        dev_en  = 1'b1;
        dev_lat = 0;
        run_cmd(1'b1, 8'h10, 32'hDEAD_BEEF, reqc, ok, got);
        ref_mem[8'h10] = 32'hDEAD_BEEF;
        @(negedge clock);
        dev_lat = 1;
        run_cmd(1'b0, 8'h10, 32'h0, reqc, ok, got);
        total++;
        if (!got || reqc !== 2 || !ok) begin
            bad++;
            $display("FAIL read_handshake: got=%0b reqcycles=%0d ok=%0b want 1/2/1",
                     got, reqc, ok);
        end
        total++;
        if (resp_data !== 32'hDEAD_BEEF || resp_error !== 1'b0) begin
            bad++;
            $display("FAIL read_resp: data=%h err=%b want deadbeef/0",
                     resp_data, resp_error);
        end
        @(negedge clock);
    endtask

    task automatic test_timeout();
        int reqc;
        bit ok, got;
        dev_en = 1'b0;
        run_cmd(1'b0, 8'h99, 32'h0, reqc, ok, got);
        total++;
        if (!got || reqc !== 4 || !ok) begin
            bad++;
            $display("FAIL timeout_len: got=%0b reqcycles=%0d ok=%0b want 1/4/1",
                     got, reqc, ok);
        end
        total++;
        if (resp_error !== 1'b1 || resp_data !== '0) begin
            bad++;
            $display("FAIL timeout_resp: err=%b data=%h want 1/0", resp_error, resp_data);
        end
        @(negedge clock);
        dev_en  = 1'b1;
        dev_lat = 3;
        run_cmd(1'b0, 8'h42, 32'h0, reqc, ok, got);
        total++;
        if (!got || reqc !== 4 || resp_error !== 1'b0 ||
            resp_data !== 32'h1234_5678) begin
            bad++;
            $display("FAIL timeout_ack_wins: reqcycles=%0d err=%b data=%h want 4/0/12345678",
                     reqc, resp_error, resp_data);
        end
        @(negedge clock);
    endtask

    task automatic test_backpressure();
        int reqc;
        bit ok, got;
        bit stable;
        dev_en     = 1'b1;
        dev_lat    = 0;
        resp_ready = 1'b0;
        run_cmd(1'b0, 8'h42, 32'h0, reqc, ok, got);
        stable = got;
        for (int i = 0; i < 5; i++) begin
            if (resp_valid !== 1'b1 || cmd_ready !== 1'b0 ||
                resp_data !== 32'h1234_5678 || resp_error !== 1'b0)
                stable = 1'b0;
            @(negedge clock);
        end
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL backpressure_hold: valid=%b ready=%b data=%h want 1/0/12345678",
                     resp_valid, cmd_ready, resp_data);
        end
        resp_ready = 1'b1;
        @(negedge clock);
        total++;
        if (cmd_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL backpressure_release: cmd_ready=%b resp_valid=%b want 1/0",
                     cmd_ready, resp_valid);
        end
    endtask

    task automatic test_reset_mid_write();
        bit quiet;
        dev_en    = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_index = 8'h33;
        cmd_data  = 32'hCAFE_F00D;
        @(negedge clock);
        cmd_valid = 1'b0;
        @(negedge clock);
        total++;
        if (mio.write_req !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre: write_req=%b want 1", mio.write_req);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (mio.write_req !== 1'b0 || mio.write_data !== '0 ||
            cmd_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_async: write_req=%b wd=%h ready=%b valid=%b want 0/0/1/0",
                     mio.write_req, mio.write_data, cmd_ready, resp_valid);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        extra_wack = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            extra_wack = 1'b0;
            if (resp_valid !== 1'b0 || cmd_ready !== 1'b1 || mio.write_req !== 1'b0)
                quiet = 1'b0;
        end
        total++;
        if (!quiet) begin
            bad++;
            $display("FAIL rst_late_ack: valid=%b ready=%b write_req=%b want 0/1/0",
                     resp_valid, cmd_ready, mio.write_req);
        end
    endtask

    task automatic test_back_to_back();
        int reqc;
        bit ok, got, wr;
        logic [IW-1:0] idx;
        logic [DW-1:0] d, exp;
        int lat;
        dev_en = 1'b1;
        for (int n = 0; n < 100; n++) begin
            wr      = bit'($urandom_range(0, 1));
            idx     = IW'($urandom_range(0, 15));
            d       = $urandom;
            lat     = $urandom_range(0, 3);
            dev_lat = lat;
            exp     = wr ? '0 : ref_mem[idx];
            if (wr) ref_mem[idx] = d;
            run_cmd(wr, idx, d, reqc, ok, got);
            total++;
            if (!got || !ok || reqc !== lat + 1 || resp_data !== exp ||
                resp_error !== 1'b0) begin
                bad++;
                $display("FAIL b2b_%0d: wr=%0b idx=%h got=%0b ok=%0b reqc=%0d/%0d data=%h want %h err=%b",
                         n, wr, idx, got, ok, reqc, lat + 1, resp_data, exp, resp_error);
            end
            @(negedge clock);
            total++;
            if (cmd_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready_%0d: cmd_ready=%b want 1", n, cmd_ready);
            end
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_index  = '0;
        cmd_data   = '0;
        resp_ready = 1'b1;
        dev_en     = 1'b0;
        dev_lat    = 0;
        extra_wack = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_backpressure();
        test_reset_mid_write();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_host_controller.md
# mmio_host_controller

Initiator end of the core MMIO interface: accepts one read or write command at a time from an upstream command channel, drives it onto an `mmio_if.host` port with a held request/acknowledge handshake, and returns the result on a response channel. It sits between the off-core configuration path (test harness, system bus bridge) and the core memory mapper. A per-transaction timeout converts a missing acknowledge (unmapped index, hung device) into an error response instead of a deadlock.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 256: maximum cycles a request is held without acknowledge. 0 disables the timeout. Legal range is 0..65535.

Ports:
- `clock`  in  1: single clock.
- `reset`  in  1: asynchronous, active-high.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: controller can accept a command.
- `cmd_write`  in  1: 1 = write, 0 = read.
- `cmd_index`  in  `TIA_MMIO_INDEX_WIDTH`: target word index.
- `cmd_data`  in  `TIA_MMIO_DATA_WIDTH`: write data; ignored for reads.
- `resp_valid`  out  1: response present.
- `resp_ready`  in  1: consumer accepts the response.
- `resp_data`  out  `TIA_MMIO_DATA_WIDTH`: read data. 0 for writes and errors.
- `resp_error`  out  1: transaction timed out.
- `mmio`  `mmio_if.host`: drives `read_req`, `read_index`, `write_req`, `write_index`, `write_data`; samples `read_ack`, `read_data`, `write_ack`.

## Operation
- States:
  - `IDLE`: `cmd_ready`=1. On `cmd_valid`, register op, index and data. Go to `READ_WAIT` or `WRITE_WAIT`.
  - `READ_WAIT`: `read_req`=1 with `read_index` stable.
    - On `read_ack`=1: capture `read_data` into `resp_data`, clear `resp_error`, go to `RESPOND`.
  - `WRITE_WAIT`: `write_req`=1 with `write_index` and `write_data` stable.
    - On `write_ack`=1: set `resp_data`=0, clear `resp_error`, go to `RESPOND`.
  - `RESPOND`: `resp_valid`=1 with `resp_data` and `resp_error` held. On `resp_ready`=1, go to `IDLE`.
- Request signals are registered outputs. When not in a WAIT state, every `mmio` output is 0, including index and data.
- Only one of `read_req` or `write_req` is ever high, never both.
- Timeout counter (16-bit):
  - Cleared on entry to a WAIT state.
  - Increments each cycle in the WAIT state without acknowledge.
  - When the count equals `TIMEOUT_CYCLES - 1` with no acknowledge in that cycle: go to `RESPOND` with `resp_error`=1 and `resp_data`=0.
- Acknowledge arriving in the same cycle the timeout expires: acknowledge wins, no error.
- A late acknowledge (while not in a WAIT state) is ignored.
- Acknowledge of the wrong type (for example `write_ack` during `READ_WAIT`) is ignored.
- Reset, including mid-transaction:
  - State goes to `IDLE` and the counter clears.
  - All outputs return to their reset values immediately (asynchronously). The in-flight command is dropped without a response.

## Timing
- Reset values:
  - `cmd_ready`=1.
  - `resp_valid`=0, `resp_data`=0, `resp_error`=0.
  - All `mmio` host outputs = 0.
- Accept handshake (cycle N: `cmd_valid` and `cmd_ready` both high):
  - N+1: request high. `cmd_ready` stays 0 from N+1 until the cycle after the response handshake.
- Acknowledge handshake (`ack` sampled high at cycle M):
  - M+1: request low, `resp_valid` high.
  - If `resp_ready` is high in M+1, `cmd_ready`=1 in M+2.
- Best-case throughput: 3 cycles per transaction, with a device that acknowledges in the first request cycle and `resp_ready` tied high.
- Timeout path: request held for exactly `TIMEOUT_CYCLES` cycles, then `resp_valid` rises on the next cycle.
- Response outputs remain stable while `resp_valid`=1 and `resp_ready`=0.

## Structure
- Shared MMIO package holds:
  - `mmio_host_state_t` enum (`IDLE`, `READ_WAIT`, `WRITE_WAIT`, `RESPOND`).
  - The `TIA_MMIO_INDEX_WIDTH` and `TIA_MMIO_DATA_WIDTH` constants.
  - A `MMIO_TIMEOUT_COUNTER_WIDTH` constant (16).
- Single module. No sub-module: the timeout counter is inline.
- One `always_ff` for state, counter and registered outputs; one `always_comb` for next-state logic.

## Test plan
- Read with a device that acknowledges 1 cycle after `read_req` rises, returning 0xDEADBEEF at index 0x10.
  - Required: `read_index`=0x10 held for 2 cycles; `resp_data`=0xDEADBEEF, `resp_error`=0.
- Write 0x12345678 to index 0x42 with an immediate `write_ack`.
  - Required: `write_req` high exactly 1 cycle; `resp_valid` follows next cycle with `resp_data`=0, `resp_error`=0; `read_req` never high.
- `TIMEOUT_CYCLES`=4 and no acknowledge.
  - Required: `read_req` high exactly 4 cycles, then `resp_error`=1, `resp_data`=0.
  - Repeat with `read_ack` in the 4th request cycle: `resp_error`=0.
- Back-pressure: hold `resp_ready`=0 for 5 cycles after the response.
  - Required: response outputs stable and `cmd_ready`=0 throughout; `cmd_ready`=1 the cycle after `resp_ready` rises.
- Assert `reset` during `WRITE_WAIT`.
  - Required: `write_req`=0 in the same cycle; `cmd_ready`=1 after release; no `resp_valid`; a late `write_ack` afterwards is ignored.
- 100 random back-to-back reads and writes against a memory model with 0-3 cycle acknowledge latency.
  - Required: all read data matches the model; one-hot requests held throughout.
